ranger_sched: RTL and testbench

RANGER_SCHED -- requirements
Module: ranger_sched

---
 rtl/ranger_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_ranger_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ranger_sched.sv
// ranger_sched: round-robin ultrasonic ranging scheduler.
// Triggers one enabled sensor at a time, times its echo, hands the result
// over a valid/ready port, then waits a holdoff gap before the next trigger.
// Build option RANGER_DIST_EN adds meas_dist_mm (width * 11 >> 6, saturated)
// at the cost of one extra cycle before each result is presented.
module ranger_sched #(
    parameter int unsigned NUM_SENSORS    = 4,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned ECHO_TIMEOUT   = 1900000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    output logic [NUM_SENSORS-1:0] trig,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic                   meas_valid,
    input  logic                   meas_ready,
    output logic [2:0]             meas_id,
    output logic [31:0]            meas_width,
    output logic                   meas_timeout,
    output logic                   busy
`ifdef RANGER_DIST_EN
    ,
    output logic [15:0]            meas_dist_mm
`endif
);

    localparam int unsigned IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] ECHO_LAST = 32'(ECHO_TIMEOUT - 1);
    localparam logic [31:0] ECHO_MAX  = 32'(ECHO_TIMEOUT);
    localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG      = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] MEASURE   = 3'd3;
    localparam logic [2:0] REPORT    = 3'd4;
    localparam logic [2:0] HOLDOFF   = 3'd5;
`ifdef RANGER_DIST_EN
    localparam logic [2:0] CALC      = 3'd6;
    localparam logic [2:0] RPT_ENTRY = CALC;
`else
    localparam logic [2:0] RPT_ENTRY = REPORT;
`endif

    logic [2:0]             state, state_n;
    logic [31:0]            cnt, cnt_n;
    logic [2:0]             sel, sel_n;
    logic [2:0]             last, last_n;
    logic [NUM_SENSORS-1:0] echo_s1, echo_s2;
    logic [NUM_SENSORS-1:0] trig_n;
    logic [2:0]             id_n;
    logic [31:0]            width_n;
    logic                   tmo_n;
    logic [2:0]             rr_next;
    logic                   hi_found, lo_found;
    logic [2:0]             hi_idx, lo_idx;
    logic                   echo_hit;
`ifdef RANGER_DIST_EN
    logic [15:0]            dist_n;
    logic [35:0]            dist_wide;

    assign dist_wide = (36'(meas_width) * 36'd11) >> 6;
`endif

    // Round-robin pick: first set mask bit above the last served index, else lowest set bit.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            if (sensor_mask[IW'(i)]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = 3'(i);
                end
                if (!hi_found && (3'(i) > last)) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        rr_next = hi_found ? hi_idx : lo_idx;
    end

    // Synchronized echo of the currently selected sensor.
    always_comb begin
        echo_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            if (sel == 3'(i)) begin
                echo_hit = echo_s2[IW'(i)];
            end
        end
    end

    // Next-state and datapath decisions; result fields only change on the way into a report.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        last_n  = last;
        id_n    = meas_id;
        width_n = meas_width;
        tmo_n   = meas_timeout;
`ifdef RANGER_DIST_EN
        dist_n  = meas_dist_mm;
`endif
        case (state)
            IDLE: begin
                if (enable && (|sensor_mask)) begin
                    state_n = TRIG;
                    sel_n   = rr_next;
                    last_n  = rr_next;
                    cnt_n   = 32'd0;
                end
            end
            TRIG: begin
                if (cnt >= TRIG_LAST) begin
                    state_n = WAIT_RISE;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            WAIT_RISE: begin
                if (echo_hit) begin
                    state_n = MEASURE;
                    cnt_n   = 32'd1;
                end else if (cnt >= ECHO_LAST) begin
                    state_n = RPT_ENTRY;
                    id_n    = sel;
                    width_n = 32'd0;
                    tmo_n   = 1'b1;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            MEASURE: begin
                if (!echo_hit) begin
                    state_n = RPT_ENTRY;
                    id_n    = sel;
                    width_n = cnt;
                    tmo_n   = 1'b0;
                    cnt_n   = 32'd0;
                end else if (cnt >= ECHO_LAST) begin
                    state_n = RPT_ENTRY;
                    id_n    = sel;
                    width_n = ECHO_MAX;
                    tmo_n   = 1'b1;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
`ifdef RANGER_DIST_EN
            CALC: begin
                state_n = REPORT;
                dist_n  = (|dist_wide[35:16]) ? 16'hFFFF : dist_wide[15:0];
            end
`endif
            REPORT: begin
                if (meas_ready) begin
                    state_n = HOLDOFF;
                    cnt_n   = 32'd0;
                end
            end
            HOLDOFF: begin
                if (cnt >= HOLD_LAST) begin
                    state_n = IDLE;
                    cnt_n   = 32'd0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 32'd0;
            end
        endcase
    end

    // Trigger is one-hot on the selected sensor for exactly the TRIG state cycles.
    always_comb begin
        trig_n = '0;
        for (int i = 0; i < int'(NUM_SENSORS); i++) begin
            trig_n[IW'(i)] = (state_n == TRIG) && (sel_n == 3'(i));
        end
    end

    // State, counters, echo synchronizers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            sel          <= 3'd0;
            last         <= 3'(NUM_SENSORS - 1);
            echo_s1      <= '0;
            echo_s2      <= '0;
            trig         <= '0;
            meas_valid   <= 1'b0;
            meas_id      <= 3'd0;
            meas_width   <= 32'd0;
            meas_timeout <= 1'b0;
            busy         <= 1'b0;
`ifdef RANGER_DIST_EN
            meas_dist_mm <= 16'd0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sel          <= sel_n;
            last         <= last_n;
            echo_s1      <= echo;
            echo_s2      <= echo_s1;
            trig         <= trig_n;
            meas_valid   <= (state_n == REPORT);
            meas_id      <= id_n;
            meas_width   <= width_n;
            meas_timeout <= tmo_n;
            busy         <= (state_n != IDLE);
`ifdef RANGER_DIST_EN
            meas_dist_mm <= dist_n;
`endif
        end
    end

endmodule

// File: tb/tb_ranger_sched.sv
// tb_ranger_sched: directed bench for ranger_sched with short timing parameters
// (TRIG=4, ECHO_TIMEOUT=100, HOLDOFF=10, 4 sensors). Handles RANGER_DIST_EN builds.
`timescale 1ns/1ps
module tb_ranger_sched;

`ifdef RANGER_DIST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        meas_ready = 1'b1;
    logic [3:0]  sensor_mask = 4'b0000;
    logic [3:0]  echo = 4'b0000;
    logic [3:0]  trig;
    logic        meas_valid;
    logic [2:0]  meas_id;
    logic [31:0] meas_width;
    logic        meas_timeout;
    logic        busy;
`ifdef RANGER_DIST_EN
    logic [15:0] meas_dist_mm;
`endif

    int errors = 0;
    int checks = 0;

    ranger_sched #(
        .NUM_SENSORS(4),
        .TRIG_CYCLES(4),
        .ECHO_TIMEOUT(100),
        .HOLDOFF_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sensor_mask(sensor_mask),
        .trig(trig),
        .echo(echo),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .meas_id(meas_id),
        .meas_width(meas_width),
        .meas_timeout(meas_timeout),
        .busy(busy)
`ifdef RANGER_DIST_EN
        ,
        .meas_dist_mm(meas_dist_mm)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Step negedges until any trigger fires (bounded), then compare the one-hot pattern.
    task automatic wait_trig(input string tag, input logic [3:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (trig != 4'b0000) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check(tag, 32'(trig), 32'(exp));
    endtask

    // Count negedges with trigger high; ends on the first negedge with trigger low.
    task automatic trig_len(output int n);
        n = 0;
        while (trig != 4'b0000 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Count negedges until meas_valid (bounded).
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!meas_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(meas_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;

        // Reset state, with scan already requested
        sensor_mask = 4'b0101;
        enable      = 1'b1;
        meas_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_trig",    32'(trig),         32'd0);
        check("rst_valid",   32'(meas_valid),   32'd0);
        check("rst_busy",    32'(busy),         32'd0);
        check("rst_id",      32'(meas_id),      32'd0);
        check("rst_width",   meas_width,        32'd0);
        check("rst_timeout", 32'(meas_timeout), 32'd0);
        reset = 1'b0;

        // Sensor 0 first, 4-cycle trigger, 20-cycle echo
        wait_trig("t1_trig", 4'b0001);
        check("t1_busy", 32'(busy), 32'd1);
        trig_len(n);
        check("t1_trig_len", 32'(n), 32'd4);
        echo[0] = 1'b1;
        repeat (20) @(negedge clk);
        echo[0] = 1'b0;
        wait_valid("t1", n);
        check("t1_id",      32'(meas_id),      32'd0);
        check("t1_width",   meas_width,        32'd20);
        check("t1_timeout", 32'(meas_timeout), 32'd0);
`ifdef RANGER_DIST_EN
        check("t1_dist",    32'(meas_dist_mm), 32'd3);
`endif

        // Sensor 2 next, no echo: timeout after 100 waiting cycles, consumer stalled
        wait_trig("t2_trig", 4'b0100);
        meas_ready = 1'b0;
        trig_len(n);
        check("t2_trig_len", 32'(n), 32'd4);
        wait_valid("t2", n);
        check("t2_wait_cycles", 32'(n), 32'(100 + LAT));
        check("t2_id",      32'(meas_id),      32'd2);
        check("t2_width",   meas_width,        32'd0);
        check("t2_timeout", 32'(meas_timeout), 32'd1);

        // Stall 50 cycles: result held, no triggering
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!(meas_valid && meas_id == 3'd2 && meas_width == 32'd0 &&
                  meas_timeout && trig == 4'b0000 && busy)) ok = 1'b0;
        end
        check("t3_stall_stable", 32'(ok), 32'd1);
        meas_ready = 1'b1;
        @(negedge clk);
        n = 1;
        check("t3_valid_drop", 32'(meas_valid), 32'd0);
        while (trig == 4'b0000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_holdoff_gap", 32'(n), 32'd12);
        check("t3_rr_wrap", 32'(trig), 32'd1);

        // Echo held high far past the timeout: saturates at 100
        trig_len(n);
        check("t4_trig_len", 32'(n), 32'd4);
        echo[0] = 1'b1;
        wait_valid("t4", n);
        check("t4_id",      32'(meas_id),      32'd0);
        check("t4_width",   meas_width,        32'd100);
        check("t4_timeout", 32'(meas_timeout), 32'd1);

        // Reset during MEASURE on sensor 2
        wait_trig("t5_trig", 4'b0100);
        echo[0] = 1'b0;
        trig_len(n);
        echo[2] = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_busy_measure", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_trig",  32'(trig),       32'd0);
        check("t5_rst_valid", 32'(meas_valid), 32'd0);
        check("t5_rst_busy",  32'(busy),       32'd0);
        echo = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        wait_trig("t5_restart", 4'b0001);
        check("t5_no_result", 32'(meas_valid), 32'd0);

        // Reset during TRIG drops the trigger without waiting for a clock
        @(negedge clk);
        check("t6_trig_mid", 32'(trig), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_trig_async", 32'(trig), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_trig("t6_restart", 4'b0001);

        // Empty mask with enable high: stays idle
        reset = 1'b1;
        sensor_mask = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy || trig != 4'b0000 || meas_valid) ok = 1'b0;
        end
        check("t7_empty_mask_idle", 32'(ok), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
